// File: rtl/ssd1306_spi_receiver_if.sv
// SSD1306 4-wire write-only SPI pins: D0/SCLK, D1/MOSI, DC and RES.
// The driver side owns every wire; the display side only listens.
interface ssd1306_spi_receiver_if;
    logic i_SPI_Clk;
    logic i_SPI_MOSI;
    logic i_DC;
    logic i_RES;

    modport master (
        output i_SPI_Clk,
        output i_SPI_MOSI,
        output i_DC,
        output i_RES
    );

    modport slave (
        input i_SPI_Clk,
        input i_SPI_MOSI,
        input i_DC,
        input i_RES
    );
endinterface

// File: rtl/ssd1306_spi_receiver.sv
// Display-side SSD1306 SPI model: deframes bytes and decodes commands.
// Data bytes become framebuffer writes at the current column/page pointer.
module ssd1306_spi_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_L,
    ssd1306_spi_receiver_if.slave       spi,
    output logic [7:0]                  o_Byte,
    output logic                        o_Byte_DV,
    output logic                        o_Byte_Is_Data,
    output logic                        o_FB_Wr,
    output logic [9:0]                  o_FB_Addr,
    output logic [7:0]                  o_FB_Data,
    output logic                        o_Display_On,
    output logic [7:0]                  o_Contrast,
    output logic                        o_Frame_Done
);

    typedef enum logic [1:0] {IDLE, ARG1, ARG2} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic [SYNC_STAGES-1:0] res_sync;
    logic                   sclk_q;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   dc_s;
    logic                   res_s;
    logic                   rise;

    state_t      state;
    logic [7:0]  opcode;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic [6:0]  col_start;
    logic [6:0]  col_end;
    logic [2:0]  page_start;
    logic [2:0]  page_end;
    logic [6:0]  col;
    logic [2:0]  page;
    logic [1:0]  mem_mode;

    logic [1:0]  n_args;
    logic [6:0]  col_nx;
    logic [2:0]  page_nx;
    logic        fd_nx;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign dc_s   = dc_sync[SYNC_STAGES-1];
    assign res_s  = res_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            dc_sync   <= '0;
            res_sync  <= '1;
            sclk_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.i_SPI_Clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.i_SPI_MOSI};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi.i_DC};
            res_sync  <= {res_sync[SYNC_STAGES-2:0], spi.i_RES};
            sclk_q    <= sclk_s;
        end
    end

    always_comb begin
        n_args = 2'd0;
        case (o_Byte)
            8'h21, 8'h22: n_args = 2'd2;
            8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
            8'hD5, 8'hD9, 8'hDA, 8'hDB: n_args = 2'd1;
            default: n_args = 2'd0;
        endcase
    end

    // Reversed windows simply wrap the counter until it meets the end value.
    always_comb begin
        col_nx  = col + 7'd1;
        page_nx = page;
        fd_nx   = 1'b0;
        if (col == col_end) begin
            col_nx = col_start;
            if (mem_mode == 2'd0) begin
                if (page == page_end) begin
                    page_nx = page_start;
                    fd_nx   = 1'b1;
                end else begin
                    page_nx = page + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Byte         <= 8'h00;
            o_Byte_DV      <= 1'b0;
            o_Byte_Is_Data <= 1'b0;
            o_FB_Wr        <= 1'b0;
            o_FB_Addr      <= 10'h000;
            o_FB_Data      <= 8'h00;
            o_Display_On   <= 1'b0;
            o_Contrast     <= 8'h7F;
            o_Frame_Done   <= 1'b0;
            state          <= IDLE;
            opcode         <= 8'h00;
            shift          <= 8'h00;
            bit_cnt        <= 3'd0;
            col_start      <= 7'd0;
            col_end        <= 7'd127;
            page_start     <= 3'd0;
            page_end       <= 3'd7;
            col            <= 7'd0;
            page           <= 3'd0;
            mem_mode       <= 2'd0;
        end else if (!res_s) begin
            o_Byte         <= 8'h00;
            o_Byte_DV      <= 1'b0;
            o_Byte_Is_Data <= 1'b0;
            o_FB_Wr        <= 1'b0;
            o_FB_Addr      <= 10'h000;
            o_FB_Data      <= 8'h00;
            o_Display_On   <= 1'b0;
            o_Contrast     <= 8'h7F;
            o_Frame_Done   <= 1'b0;
            state          <= IDLE;
            opcode         <= 8'h00;
            shift          <= 8'h00;
            bit_cnt        <= 3'd0;
            col_start      <= 7'd0;
            col_end        <= 7'd127;
            page_start     <= 3'd0;
            page_end       <= 3'd7;
            col            <= 7'd0;
            page           <= 3'd0;
            mem_mode       <= 2'd0;
        end else begin
            o_Byte_DV    <= 1'b0;
            o_FB_Wr      <= 1'b0;
            o_Frame_Done <= 1'b0;

            if (rise) begin
                shift   <= {shift[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    o_Byte         <= {shift[6:0], mosi_s};
                    o_Byte_Is_Data <= dc_s;
                    o_Byte_DV      <= 1'b1;
                end
            end

            if (o_Byte_DV) begin
                if (o_Byte_Is_Data) begin
                    state        <= IDLE;
                    o_FB_Wr      <= 1'b1;
                    o_FB_Addr    <= {page, col};
                    o_FB_Data    <= o_Byte;
                    col          <= col_nx;
                    page         <= page_nx;
                    o_Frame_Done <= fd_nx;
                end else begin
                    case (state)
                        IDLE: begin
                            opcode <= o_Byte;
                            if (o_Byte == 8'hAE) o_Display_On <= 1'b0;
                            if (o_Byte == 8'hAF) o_Display_On <= 1'b1;
                            if (n_args != 2'd0) state <= ARG1;
                        end
                        ARG1: begin
                            case (opcode)
                                8'h21: begin
                                    col_start <= o_Byte[6:0];
                                    col       <= o_Byte[6:0];
                                end
                                8'h22: begin
                                    page_start <= o_Byte[2:0];
                                    page       <= o_Byte[2:0];
                                end
                                8'h20: mem_mode   <= o_Byte[1:0];
                                8'h81: o_Contrast <= o_Byte;
                                default: ;
                            endcase
                            if (opcode == 8'h21 || opcode == 8'h22)
                                state <= ARG2;
                            else
                                state <= IDLE;
                        end
                        ARG2: begin
                            case (opcode)
                                8'h21: col_end  <= o_Byte[6:0];
                                8'h22: page_end <= o_Byte[2:0];
                                default: ;
                            endcase
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// Directed bench for ssd1306_spi_receiver: command table plus
// hand-written reset, full-frame and display-reset sequences.
module tb_ssd1306_spi_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] o_Byte;
    logic       o_Byte_DV;
    logic       o_Byte_Is_Data;
    logic       o_FB_Wr;
    logic [9:0] o_FB_Addr;
    logic [7:0] o_FB_Data;
    logic       o_Display_On;
    logic [7:0] o_Contrast;
    logic       o_Frame_Done;

    ssd1306_spi_receiver_if spi ();

    ssd1306_spi_receiver #(.SYNC_STAGES(2)) dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .spi            (spi),
        .o_Byte         (o_Byte),
        .o_Byte_DV      (o_Byte_DV),
        .o_Byte_Is_Data (o_Byte_Is_Data),
        .o_FB_Wr        (o_FB_Wr),
        .o_FB_Addr      (o_FB_Addr),
        .o_FB_Data      (o_FB_Data),
        .o_Display_On   (o_Display_On),
        .o_Contrast     (o_Contrast),
        .o_Frame_Done   (o_Frame_Done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         dv_cnt = 0;
    int         wr_cnt = 0;
    int         fd_cnt = 0;
    int         dv_cyc = 0;
    int         wr_cyc = 0;
    int         seq_bad = 0;
    logic [7:0] last_byte = 8'h00;
    logic       last_isd = 1'b0;
    logic [9:0] last_addr = 10'h000;
    logic [7:0] last_data = 8'h00;
    logic       last_fd = 1'b0;
    bit         seq_on = 1'b0;
    int         seq_base = 0;

    always @(negedge clk) begin
        cyc++;
        if (o_Byte_DV) begin
            dv_cnt++;
            dv_cyc = cyc;
            last_byte = o_Byte;
            last_isd = o_Byte_Is_Data;
        end
        if (o_FB_Wr) begin
            if (seq_on && int'(o_FB_Addr) != wr_cnt - seq_base)
                seq_bad++;
            wr_cnt++;
            wr_cyc = cyc;
            last_addr = o_FB_Addr;
            last_data = o_FB_Data;
            last_fd = o_Frame_Done;
        end
        if (o_Frame_Done) fd_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input bit dc, input logic [7:0] b,
                             input int n, input int hp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            spi.i_DC = dc;
            spi.i_SPI_MOSI = b[7-i];
            spi.i_SPI_Clk = 1'b0;
            repeat (hp) @(negedge clk);
            spi.i_SPI_Clk = 1'b1;
            repeat (hp - 1) @(negedge clk);
        end
        @(negedge clk);
        spi.i_SPI_Clk = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        settle();
    endtask

    typedef struct {
        bit         dc;
        logic [7:0] val;
        bit         wr;
        logic [9:0] addr;
        bit         fd;
        bit         disp;
        logic [7:0] con;
    } vec_t;

    vec_t tbl [17];

    int d0, w0, f0;

    initial begin
        tbl[0]  = '{1'b0, 8'hAF, 1'b0, 10'h000, 1'b0, 1'b1, 8'h7F};
        tbl[1]  = '{1'b0, 8'h81, 1'b0, 10'h000, 1'b0, 1'b1, 8'h7F};
        tbl[2]  = '{1'b1, 8'h11, 1'b1, 10'h000, 1'b0, 1'b1, 8'h7F};
        tbl[3]  = '{1'b0, 8'hAE, 1'b0, 10'h000, 1'b0, 1'b0, 8'h7F};
        tbl[4]  = '{1'b0, 8'h81, 1'b0, 10'h000, 1'b0, 1'b0, 8'h7F};
        tbl[5]  = '{1'b0, 8'h40, 1'b0, 10'h000, 1'b0, 1'b0, 8'h40};
        tbl[6]  = '{1'b0, 8'h21, 1'b0, 10'h000, 1'b0, 1'b0, 8'h40};
        tbl[7]  = '{1'b0, 8'h04, 1'b0, 10'h000, 1'b0, 1'b0, 8'h40};
        tbl[8]  = '{1'b0, 8'h05, 1'b0, 10'h000, 1'b0, 1'b0, 8'h40};
        tbl[9]  = '{1'b0, 8'h22, 1'b0, 10'h000, 1'b0, 1'b0, 8'h40};
        tbl[10] = '{1'b0, 8'h06, 1'b0, 10'h000, 1'b0, 1'b0, 8'h40};
        tbl[11] = '{1'b0, 8'h07, 1'b0, 10'h000, 1'b0, 1'b0, 8'h40};
        tbl[12] = '{1'b1, 8'hD0, 1'b1, 10'h304, 1'b0, 1'b0, 8'h40};
        tbl[13] = '{1'b1, 8'hD1, 1'b1, 10'h305, 1'b0, 1'b0, 8'h40};
        tbl[14] = '{1'b1, 8'hD2, 1'b1, 10'h384, 1'b0, 1'b0, 8'h40};
        tbl[15] = '{1'b1, 8'hD3, 1'b1, 10'h385, 1'b1, 1'b0, 8'h40};
        tbl[16] = '{1'b1, 8'hD4, 1'b1, 10'h304, 1'b0, 1'b0, 8'h40};

        spi.i_SPI_Clk = 1'b0;
        spi.i_SPI_MOSI = 1'b0;
        spi.i_DC = 1'b0;
        spi.i_RES = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_contrast", int'(o_Contrast), 'h7F);
        chk("rst_disp", int'(o_Display_On), 0);
        chk("rst_byte", int'(o_Byte), 0);
        chk("rst_dv", int'(o_Byte_DV), 0);
        chk("rst_wr", int'(o_FB_Wr), 0);
        chk("rst_addr", int'(o_FB_Addr), 0);
        chk("rst_fd", int'(o_Frame_Done), 0);

        // reset in the middle of a byte must discard the partial bits
        rst_n = 1'b1;
        settle();
        send_bits(1'b0, 8'hFF, 3, 4);
        hard_reset();
        d0 = dv_cnt;
        send_bits(1'b0, 8'hAF, 8, 4);
        settle();
        chk("midrst_dv", dv_cnt - d0, 1);
        chk("midrst_byte", int'(last_byte), 'hAF);
        chk("midrst_disp", int'(o_Display_On), 1);
        chk("midrst_contrast", int'(o_Contrast), 'h7F);

        // single data byte at i_Clk/8
        d0 = dv_cnt;
        w0 = wr_cnt;
        send_bits(1'b1, 8'hA5, 8, 4);
        settle();
        chk("dfr_dv", dv_cnt - d0, 1);
        chk("dfr_byte", int'(last_byte), 'hA5);
        chk("dfr_isd", int'(last_isd), 1);
        chk("dfr_wr", wr_cnt - w0, 1);
        chk("dfr_addr", int'(last_addr), 'h000);
        chk("dfr_data", int'(last_data), 'hA5);
        chk("dfr_lat", wr_cyc - dv_cyc, 1);

        hard_reset();
        f0 = fd_cnt;
        for (int i = 0; i < 17; i++) begin
            d0 = dv_cnt;
            w0 = wr_cnt;
            send_bits(tbl[i].dc, tbl[i].val, 8, 4);
            settle();
            chk($sformatf("v%0d_dv", i), dv_cnt - d0, 1);
            chk($sformatf("v%0d_byte", i), int'(last_byte), int'(tbl[i].val));
            chk($sformatf("v%0d_isd", i), int'(last_isd), int'(tbl[i].dc));
            chk($sformatf("v%0d_wr", i), wr_cnt - w0, int'(tbl[i].wr));
            if (tbl[i].wr) begin
                chk($sformatf("v%0d_addr", i), int'(last_addr), int'(tbl[i].addr));
                chk($sformatf("v%0d_data", i), int'(last_data), int'(tbl[i].val));
                chk($sformatf("v%0d_fd", i), int'(last_fd), int'(tbl[i].fd));
            end
            chk($sformatf("v%0d_disp", i), int'(o_Display_On), int'(tbl[i].disp));
            chk($sformatf("v%0d_con", i), int'(o_Contrast), int'(tbl[i].con));
        end
        chk("win_fd_count", fd_cnt - f0, 1);

        // full 128x8 frame in horizontal mode at i_Clk/4
        hard_reset();
        w0 = wr_cnt;
        f0 = fd_cnt;
        d0 = seq_bad;
        seq_base = wr_cnt;
        seq_on = 1'b1;
        for (int k = 0; k < 1024; k++)
            send_bits(1'b1, 8'(k), 8, 2);
        settle();
        seq_on = 1'b0;
        chk("frame_wr", wr_cnt - w0, 1024);
        chk("frame_order", seq_bad - d0, 0);
        chk("frame_fd_count", fd_cnt - f0, 1);
        chk("frame_fd_last", int'(last_fd), 1);
        chk("frame_last_addr", int'(last_addr), 'h3FF);
        send_bits(1'b1, 8'h3C, 8, 2);
        settle();
        chk("frame_wrap_addr", int'(last_addr), 'h000);

        // display reset mid-command and mid-byte
        hard_reset();
        send_bits(1'b0, 8'h81, 8, 4);
        send_bits(1'b0, 8'h22, 8, 4);
        settle();
        chk("res_con_set", int'(o_Contrast), 'h22);
        send_bits(1'b0, 8'h21, 8, 4);
        send_bits(1'b0, 8'h10, 8, 4);
        send_bits(1'b0, 8'hFF, 3, 4);
        @(negedge clk);
        spi.i_RES = 1'b0;
        repeat (4) @(negedge clk);
        spi.i_RES = 1'b1;
        settle();
        chk("res_contrast", int'(o_Contrast), 'h7F);
        d0 = dv_cnt;
        send_bits(1'b0, 8'hAF, 8, 4);
        settle();
        chk("res_dv", dv_cnt - d0, 1);
        chk("res_byte", int'(last_byte), 'hAF);
        chk("res_idle_disp", int'(o_Display_On), 1);
        w0 = wr_cnt;
        send_bits(1'b1, 8'h5A, 8, 4);
        settle();
        chk("res_wr", wr_cnt - w0, 1);
        chk("res_addr", int'(last_addr), 'h000);
        chk("res_data", int'(last_data), 'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
